// File: rtl/sfp_link_pkg.sv
// Shared state encodings, counter width and small arithmetic helpers
// for the SFP link bring-up sequencer.
package sfp_link_pkg;

    localparam int CNT_W     = 24;
    localparam int CNT_LIMIT = 32'd16777216;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [2:0] ST_NO_MODULE = 3'd0;
    localparam logic [2:0] ST_RESET     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd3;
    localparam logic [2:0] ST_UP        = 3'd4;
    localparam logic [2:0] ST_HOLDOFF   = 3'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic cnt_t cnt_inc(input cnt_t v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + cnt_t'(1);
        end
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for one asynchronous level signal into the clk domain.
module sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sfp_link_sequencer.sv
// SFP link bring-up sequencer: module detect, GT RX reset, done/lock qualification,
// fault debounce in UP and retry holdoff with a saturating retry counter.
module sfp_link_sequencer
    import sfp_link_pkg::*;
#(
    parameter int RESET_CYCLES   = 16,
    parameter int DONE_TIMEOUT   = 1250000,
    parameter int LOCK_TIMEOUT   = 1250000,
    parameter int LOCK_STABLE    = 1024,
    parameter int HOLDOFF_CYCLES = 125000,
    parameter int DEBOUNCE       = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sfp_npres,
    input  logic       sfp_los,
    input  logic       gt_reset_rx_done,
    input  logic       rx_block_lock,
    input  logic       rx_high_ber,
    output logic       gt_rx_datapath_reset,
    output logic       sfp_tx_disable,
    output logic       link_up,
    output logic [2:0] state_out,
    output logic [7:0] retry_count
);

    if (RESET_CYCLES < 1 || RESET_CYCLES >= CNT_LIMIT) begin : g_bad_reset_cycles
        $fatal(1, "RESET_CYCLES out of range");
    end
    if (DONE_TIMEOUT < 1 || DONE_TIMEOUT >= CNT_LIMIT) begin : g_bad_done_timeout
        $fatal(1, "DONE_TIMEOUT out of range");
    end
    if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT >= CNT_LIMIT) begin : g_bad_lock_timeout
        $fatal(1, "LOCK_TIMEOUT out of range");
    end
    if (LOCK_STABLE < 1 || LOCK_STABLE >= CNT_LIMIT) begin : g_bad_lock_stable
        $fatal(1, "LOCK_STABLE out of range");
    end
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES >= CNT_LIMIT) begin : g_bad_holdoff
        $fatal(1, "HOLDOFF_CYCLES out of range");
    end
    if (DEBOUNCE < 1 || DEBOUNCE >= CNT_LIMIT) begin : g_bad_debounce
        $fatal(1, "DEBOUNCE out of range");
    end

    // Terminal counts: a counter equal to N-1 in the current cycle completes N cycles.
    localparam cnt_t RESET_LAST    = cnt_t'(RESET_CYCLES - 1);
    localparam cnt_t DONE_LAST     = cnt_t'(DONE_TIMEOUT - 1);
    localparam cnt_t LOCK_LAST     = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t STABLE_LAST   = cnt_t'(LOCK_STABLE - 1);
    localparam cnt_t HOLDOFF_LAST  = cnt_t'(HOLDOFF_CYCLES - 1);
    localparam cnt_t DEBOUNCE_LAST = cnt_t'(DEBOUNCE - 1);

    logic       npres_s;
    logic       los_s;
    logic       done_s;
    logic       lock_s;
    logic       ber_s;
    logic       good_s;
    logic       fault_s;
    logic [2:0] state_nxt_s;
    logic       retry_inc_s;

    logic [2:0] state_r;
    cnt_t       cnt_r;
    cnt_t       stable_r;
    cnt_t       fault_r;
    logic [7:0] retry_r;
    logic       gt_reset_r;
    logic       tx_disable_r;
    logic       link_up_r;

    sync_bit u_sync_npres (.clk(clk), .rst(rst), .d(sfp_npres),        .q(npres_s));
    sync_bit u_sync_los   (.clk(clk), .rst(rst), .d(sfp_los),          .q(los_s));
    sync_bit u_sync_done  (.clk(clk), .rst(rst), .d(gt_reset_rx_done), .q(done_s));
    sync_bit u_sync_lock  (.clk(clk), .rst(rst), .d(rx_block_lock),    .q(lock_s));
    sync_bit u_sync_ber   (.clk(clk), .rst(rst), .d(rx_high_ber),      .q(ber_s));

    assign good_s  = lock_s & ~ber_s;
    assign fault_s = ~lock_s | ber_s | los_s;

    // Next-state decode; success is tested ahead of each timeout, module absence overrides all.
    always_comb begin
        state_nxt_s = state_r;
        retry_inc_s = 1'b0;
        if (npres_s) begin
            state_nxt_s = ST_NO_MODULE;
        end else begin
            case (state_r)
                ST_NO_MODULE: begin
                    if (!los_s) begin
                        state_nxt_s = ST_RESET;
                    end else begin
                        state_nxt_s = ST_NO_MODULE;
                    end
                end
                ST_RESET: begin
                    if (cnt_r == RESET_LAST) begin
                        state_nxt_s = ST_WAIT_DONE;
                    end else begin
                        state_nxt_s = ST_RESET;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_s) begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end else if (cnt_r == DONE_LAST) begin
                        state_nxt_s = ST_HOLDOFF;
                        retry_inc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (good_s && stable_r == STABLE_LAST) begin
                        state_nxt_s = ST_UP;
                    end else if (cnt_r == LOCK_LAST) begin
                        state_nxt_s = ST_HOLDOFF;
                        retry_inc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_LOCK;
                    end
                end
                ST_UP: begin
                    if (fault_s && fault_r == DEBOUNCE_LAST) begin
                        state_nxt_s = ST_RESET;
                        retry_inc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_UP;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_r == HOLDOFF_LAST) begin
                        state_nxt_s = ST_RESET;
                    end else begin
                        state_nxt_s = ST_HOLDOFF;
                    end
                end
                default: begin
                    state_nxt_s = ST_NO_MODULE;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs are registered from the next state so they align with state_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_NO_MODULE;
            cnt_r        <= {CNT_W{1'b0}};
            stable_r     <= {CNT_W{1'b0}};
            fault_r      <= {CNT_W{1'b0}};
            retry_r      <= 8'd0;
            gt_reset_r   <= 1'b0;
            tx_disable_r <= 1'b1;
            link_up_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= (state_nxt_s != state_r) ? {CNT_W{1'b0}} : cnt_inc(cnt_r);
            stable_r     <= (state_r == ST_WAIT_LOCK && state_nxt_s == ST_WAIT_LOCK && good_s)
                            ? cnt_inc(stable_r) : {CNT_W{1'b0}};
            fault_r      <= (state_r == ST_UP && state_nxt_s == ST_UP && fault_s)
                            ? cnt_inc(fault_r) : {CNT_W{1'b0}};
            retry_r      <= retry_inc_s ? sat_inc8(retry_r) : retry_r;
            gt_reset_r   <= (state_nxt_s == ST_RESET);
            tx_disable_r <= (state_nxt_s == ST_NO_MODULE);
            link_up_r    <= (state_nxt_s == ST_UP);
        end
    end

    assign gt_rx_datapath_reset = gt_reset_r;
    assign sfp_tx_disable       = tx_disable_r;
    assign link_up              = link_up_r;
    assign state_out            = state_r;
    assign retry_count          = retry_r;

endmodule

// File: doc/sfp_link_sequencer.md
SFP_LINK_SEQUENCER -- requirements
Module: sfp_link_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16, is the number of cycles gt_rx_datapath_reset is held high per reset attempt.
REQ-002 Parameter DONE_TIMEOUT, default 1250000, is the maximum cycles spent waiting for gt_reset_rx_done (10 ms at 125 MHz).
REQ-003 Parameter LOCK_TIMEOUT, default 1250000, is the maximum cycles spent waiting for stable block lock.
REQ-004 Parameter LOCK_STABLE, default 1024, is the consecutive lock cycles required before link_up.
REQ-005 Parameter HOLDOFF_CYCLES, default 125000, is the wait after a failed attempt before retrying.
REQ-006 Parameter DEBOUNCE, default 64, is the consecutive fault cycles in UP that trigger a relink.
REQ-007 clk  input  1  free-running 125 MHz clock; all logic is on this clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 sfp_npres  input  1  module-absent pin (1 = absent); asynchronous.
REQ-010 sfp_los  input  1  loss-of-signal pin; asynchronous.
REQ-011 gt_reset_rx_done  input  1  GT RX reset complete; asynchronous.
REQ-012 rx_block_lock  input  1  PHY 64b/66b block lock; asynchronous (RX recovered clock).
REQ-013 rx_high_ber  input  1  PHY high-BER flag; asynchronous.
REQ-014 gt_rx_datapath_reset  output  1  drives the GT RX datapath reset request.
REQ-015 sfp_tx_disable  output  1  SFP transmitter disable.
REQ-016 link_up  output  1  link is qualified up.
REQ-017 state_out  output  3  current state encoding.
REQ-018 retry_count  output  8  count of failed attempts and relinks, saturating.

Function
REQ-019 Every asynchronous input SHALL pass through a 2-flop synchronizer before use, giving 2 cycles of latency.
REQ-020 States SHALL be NO_MODULE=0, RESET=1, WAIT_DONE=2, WAIT_LOCK=3, UP=4, HOLDOFF=5; state_out SHALL equal the current encoding.
REQ-021 NO_MODULE: sfp_tx_disable=1; go to RESET when synced npres=0 and los=0.
REQ-022 In any state, synced npres=1 SHALL force NO_MODULE on the next cycle, with priority over every other transition.
REQ-023 RESET: gt_rx_datapath_reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_DONE.
REQ-024 WAIT_DONE: go to WAIT_LOCK when synced done=1; after DONE_TIMEOUT cycles without done, go to HOLDOFF.
REQ-025 WAIT_LOCK: the stable counter SHALL increment while lock=1 and high_ber=0, and clear to 0 otherwise.
REQ-026 WAIT_LOCK: go to UP when the stable counter reaches LOCK_STABLE; after LOCK_TIMEOUT total cycles without that, go to HOLDOFF.
REQ-027 UP: link_up=1; the fault counter SHALL increment while lock=0, high_ber=1, or los=1, and clear otherwise.
REQ-028 UP: when the fault counter reaches DEBOUNCE, go to RESET and increment retry_count.
REQ-029 HOLDOFF: on entry increment retry_count; after HOLDOFF_CYCLES cycles go to RESET.
REQ-030 The single cycle counter SHALL clear on every state change.
REQ-031 retry_count SHALL saturate at 255.
REQ-032 Counters SHALL be 24 bits; every timing parameter SHALL be at least 1 and less than 2^24, checked by an elaboration-time assertion.
REQ-033 If a timeout and its success condition occur in the same cycle, success SHALL win.
REQ-034 sfp_tx_disable SHALL be 0 in every state except NO_MODULE.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While rst=1: state=NO_MODULE, sfp_tx_disable=1, gt_rx_datapath_reset=0, link_up=0, retry_count=0, and all counters and synchronizer flops are 0.
REQ-037 Reset asserted mid-operation SHALL take effect on the next clk edge regardless of state.

Structure
REQ-038 The state encodings and the counter width SHALL live in the shared package sfp_link_pkg.
REQ-039 The 2-flop synchronizer SHALL be a single sub-module, sync_bit, instantiated once per asynchronous input.

Verification
Run with RESET_CYCLES=4, DONE_TIMEOUT=50, LOCK_TIMEOUT=100, LOCK_STABLE=8, HOLDOFF_CYCLES=20, DEBOUNCE=4.
REQ-040 Normal bring-up: npres=0, los=0, done rises 10 cycles after the reset pulse, lock held -> reset pulse is exactly 4 cycles; link_up=1 exactly 8 cycles after synced lock; retry_count=0.
REQ-041 Done timeout: done stuck at 0 -> HOLDOFF after 50 cycles in WAIT_DONE; retry_count=1; new 4-cycle reset pulse 20 cycles later.
REQ-042 Lock glitch: lock drops for 1 cycle at stable count 6 -> counter clears; link_up only after 8 fresh consecutive lock cycles.
REQ-043 UP fault: high_ber=1 for 3 cycles -> link stays up; high_ber=1 for 4 cycles -> RESET, link_up=0, retry_count increments by 1.
REQ-044 Module pull: npres=1 while in UP -> NO_MODULE within 3 cycles, sfp_tx_disable=1, link_up=0; rst mid-WAIT_LOCK -> all reset values on the next cycle.
REQ-045 Saturation: 300 forced failures -> retry_count=255 and holds at 255.
